wfm_frame_packer: RTL and testbench

//  Downstream of the two DAT_FIFO instances, in the CLKB domain. Pops both FIFOs together
//  and builds one 32-bit frame per capture: header, 40-bit timestamp, sample pairs, trailer.

---
 rtl/wfm_frame_packer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_wfm_frame_packer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfm_frame_packer.sv
// wfm_frame_packer
// Pops the two channel DAT_FIFOs in lock-step and packs each capture into one
// frame of 32-bit words on a write/waitrequest sink:
//    header, timestamp high, timestamp low, one word per sample pair, trailer.
// Optional feature macro: PACK_CRC_EN. When it is defined, the trailer carries a
// CRC-16-CCITT over the accepted data words. Otherwise that field is zero and no
// CRC logic exists.
// The FIFOs are legacy-mode: q appears one cycle after rdreq and then holds until
// the next rdreq. The skid register captures q only when it has room, and a new
// pop is only issued when it has room. A stalled sink therefore never loses a pair.

module wfm_frame_packer #(
   parameter int FRAME_LEN = 1024,
   parameter int DATA_W    = 14,
   parameter int TIMEOUT   = 4095
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [39:0]       time_in,
   input  logic              trig_start,
   input  logic [DATA_W-1:0] fifo1_q,
   input  logic              fifo1_empty,
   output logic              fifo1_rdreq,
   input  logic [DATA_W-1:0] fifo2_q,
   input  logic              fifo2_empty,
   output logic              fifo2_rdreq,
   output logic [31:0]       out_data,
   output logic              out_write,
   input  logic              out_waitrequest,
   output logic [15:0]       frame_cnt,
   output logic              busy,
   output logic              trig_missed
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_TS_HI = 3'd2;
   localparam logic [2:0] S_TS_LO = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_TRAIL = 3'd5;

   localparam int          IW          = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);
   localparam logic [10:0] FRAME_LEN_C = 11'(FRAME_LEN);

   // registered state
   logic [2:0]    state_r;
   logic [39:0]   ts_r;
   logic [31:0]   out_data_r;
   logic          out_write_r;
   logic [15:0]   frame_cnt_r;
   logic          busy_r;
   logic          trig_missed_r;
   logic [31:0]   skid_r;
   logic          skid_valid_r;
   logic          q_pend_r;
   logic [10:0]   pop_cnt_r;
   logic [10:0]   acc_cnt_r;
   logic [IW-1:0] idle_cnt_r;

   // next-state values
   logic [2:0]    state_n_s;
   logic [39:0]   ts_n_s;
   logic [31:0]   out_data_n_s;
   logic          out_write_n_s;
   logic [15:0]   frame_cnt_n_s;
   logic [31:0]   skid_n_s;
   logic          skid_valid_n_s;
   logic          q_pend_n_s;
   logic [10:0]   pop_cnt_n_s;
   logic [10:0]   acc_cnt_n_s;
   logic [IW-1:0] idle_n_s;

   // handshake and datapath decode
   logic          accept_s;
   logic          out_free_s;
   logic          skid_drain_s;
   logic          skid_room_s;
   logic          capture_s;
   logic          pop_s;
   logic          data_acc_s;
   logic [10:0]   acc_inc_s;
   logic          full_done_s;
   logic          timeout_s;
   logic [31:0]   pair_word_s;
   logic [15:0]   crc_word_s;

`ifdef PACK_CRC_EN
   logic [15:0]   crc_r;
   logic [15:0]   crc_n_s;
   logic [15:0]   crc_fold_s;

   // CRC-16-CCITT, poly 0x1021, folds one 32-bit word MSB first
   function automatic logic [15:0] crc16_fold(input logic [15:0] crc_in, input logic [31:0] word);
      logic [15:0] c;
      c = crc_in;
      for (int i = 31; i >= 0; i--) begin
         if (c[15] ^ word[i]) begin
            c = {c[14:0], 1'b0} ^ 16'h1021;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   assign crc_fold_s = data_acc_s ? crc16_fold(crc_r, out_data_r) : crc_r;
   assign crc_word_s = crc_fold_s;
`else
   assign crc_word_s = 16'h0000;
`endif

   assign accept_s     = out_write_r & ~out_waitrequest;
   assign out_free_s   = ~out_write_r | ~out_waitrequest;
   assign skid_drain_s = (state_r == S_DATA) & skid_valid_r & out_free_s;
   assign skid_room_s  = ~skid_valid_r | skid_drain_s;
   assign capture_s    = q_pend_r & skid_room_s;
   assign pop_s        = ~rst & (state_r == S_DATA) & ~fifo1_empty & ~fifo2_empty &
                         (pop_cnt_r < FRAME_LEN_C) & skid_room_s;
   assign data_acc_s   = (state_r == S_DATA) & accept_s;
   assign acc_inc_s    = (data_acc_s && (acc_cnt_r != 11'h7FF)) ? (acc_cnt_r + 11'd1) : acc_cnt_r;
   assign full_done_s  = data_acc_s & (acc_inc_s == FRAME_LEN_C);
   assign timeout_s    = (state_r == S_DATA) & (idle_cnt_r == TIMEOUT_C) & ~pop_s &
                         ~skid_valid_r & ~q_pend_r & out_free_s;
   assign pair_word_s  = {16'(fifo2_q), 16'(fifo1_q)};

   assign fifo1_rdreq  = pop_s;
   assign fifo2_rdreq  = pop_s;
   assign out_data     = out_data_r;
   assign out_write    = out_write_r;
   assign frame_cnt    = frame_cnt_r;
   assign busy         = busy_r;
   assign trig_missed  = trig_missed_r;

   // next-state logic: frame sequencing, skid pipeline and counters
   always_comb begin
      state_n_s     = state_r;
      ts_n_s        = ts_r;
      out_data_n_s  = out_data_r;
      out_write_n_s = out_write_r;
      frame_cnt_n_s = frame_cnt_r;
      skid_n_s      = skid_r;
      pop_cnt_n_s   = pop_cnt_r;
      acc_cnt_n_s   = acc_inc_s;
      idle_n_s      = idle_cnt_r;
`ifdef PACK_CRC_EN
      crc_n_s       = crc_fold_s;
`endif

      if (capture_s) begin
         skid_n_s       = pair_word_s;
         skid_valid_n_s = 1'b1;
      end else if (skid_drain_s) begin
         skid_valid_n_s = 1'b0;
      end else begin
         skid_valid_n_s = skid_valid_r;
      end

      if (pop_s) begin
         q_pend_n_s  = 1'b1;
         pop_cnt_n_s = pop_cnt_r + 11'd1;
      end else if (capture_s) begin
         q_pend_n_s  = 1'b0;
      end else begin
         q_pend_n_s  = q_pend_r;
      end

      case (state_r)
         S_IDLE: begin
            if (trig_start) begin
               state_n_s      = S_HDR;
               ts_n_s         = time_in;
               out_data_n_s   = {8'hA5, 8'h00, frame_cnt_r};
               out_write_n_s  = 1'b1;
               skid_valid_n_s = 1'b0;
               q_pend_n_s     = 1'b0;
               pop_cnt_n_s    = 11'd0;
               acc_cnt_n_s    = 11'd0;
               idle_n_s       = '0;
            end else begin
               out_write_n_s  = 1'b0;
            end
         end
         S_HDR: begin
`ifdef PACK_CRC_EN
            crc_n_s = 16'hFFFF;
`endif
            if (accept_s) begin
               state_n_s    = S_TS_HI;
               out_data_n_s = {8'hB5, 16'h0000, ts_r[39:32]};
            end else begin
               state_n_s    = S_HDR;
            end
         end
         S_TS_HI: begin
            if (accept_s) begin
               state_n_s    = S_TS_LO;
               out_data_n_s = ts_r[31:0];
            end else begin
               state_n_s    = S_TS_HI;
            end
         end
         S_TS_LO: begin
            if (accept_s) begin
               state_n_s     = S_DATA;
               out_write_n_s = 1'b0;
               idle_n_s      = '0;
            end else begin
               state_n_s     = S_TS_LO;
            end
         end
         S_DATA: begin
            // idle counter measures cycles without a pop, saturating at the limit
            if (pop_s) begin
               idle_n_s = '0;
            end else if (idle_cnt_r != TIMEOUT_C) begin
               idle_n_s = idle_cnt_r + IW'(1);
            end else begin
               idle_n_s = idle_cnt_r;
            end
            if (full_done_s || timeout_s) begin
               state_n_s     = S_TRAIL;
               out_data_n_s  = {4'hE, ~full_done_s, acc_inc_s, crc_word_s};
               out_write_n_s = 1'b1;
            end else if (skid_drain_s) begin
               out_data_n_s  = skid_r;
               out_write_n_s = 1'b1;
            end else if (accept_s) begin
               out_write_n_s = 1'b0;
            end else begin
               out_write_n_s = out_write_r;
            end
         end
         S_TRAIL: begin
            if (accept_s) begin
               state_n_s     = S_IDLE;
               out_write_n_s = 1'b0;
               frame_cnt_n_s = frame_cnt_r + 16'd1;
            end else begin
               state_n_s     = S_TRAIL;
            end
         end
         default: begin
            state_n_s     = S_IDLE;
            out_write_n_s = 1'b0;
         end
      endcase
   end

   // state registers with synchronous reset; reset aborts any frame in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= S_IDLE;
         ts_r          <= 40'd0;
         out_data_r    <= 32'd0;
         out_write_r   <= 1'b0;
         frame_cnt_r   <= 16'd0;
         busy_r        <= 1'b0;
         trig_missed_r <= 1'b0;
         skid_r        <= 32'd0;
         skid_valid_r  <= 1'b0;
         q_pend_r      <= 1'b0;
         pop_cnt_r     <= 11'd0;
         acc_cnt_r     <= 11'd0;
         idle_cnt_r    <= '0;
`ifdef PACK_CRC_EN
         crc_r         <= 16'hFFFF;
`endif
      end else begin
         state_r       <= state_n_s;
         ts_r          <= ts_n_s;
         out_data_r    <= out_data_n_s;
         out_write_r   <= out_write_n_s;
         frame_cnt_r   <= frame_cnt_n_s;
         busy_r        <= (state_n_s != S_IDLE);
         trig_missed_r <= trig_start & (state_r != S_IDLE);
         skid_r        <= skid_n_s;
         skid_valid_r  <= skid_valid_n_s;
         q_pend_r      <= q_pend_n_s;
         pop_cnt_r     <= pop_cnt_n_s;
         acc_cnt_r     <= acc_cnt_n_s;
         idle_cnt_r    <= idle_n_s;
`ifdef PACK_CRC_EN
         crc_r         <= crc_n_s;
`endif
      end
   end

endmodule

// File: tb/tb_wfm_frame_packer.sv
// Bench for wfm_frame_packer (FRAME_LEN=4, DATA_W=14, TIMEOUT=32).
// Expected words are queued by the stimulus; a forked monitor compares every
// accepted output word against that queue and checks that stalled words hold.

module tb_wfm_frame_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] time_in = 40'd0;
   logic        trig_start = 1'b0;
   logic [13:0] fifo1_q = 14'd0;
   logic [13:0] fifo2_q = 14'd0;
   logic        fifo1_empty;
   logic        fifo2_empty;
   logic        fifo1_rdreq;
   logic        fifo2_rdreq;
   logic [31:0] out_data;
   logic        out_write;
   logic        out_waitrequest = 1'b0;
   logic [15:0] frame_cnt;
   logic        busy;
   logic        trig_missed;

   // FIFO models: written by stimulus (wr pointers), read by the FIFO process (rd pointers)
   logic [13:0] f1_mem [0:63];
   logic [13:0] f2_mem [0:63];
   int          f1_wr = 0, f2_wr = 0, f1_rd = 0, f2_rd = 0;

   logic [31:0] exp_q[$];
   int          exp_rd = 0;
   int          total = 0;
   int          bad = 0;
   logic [15:0] crc_m = 16'hFFFF;

   wfm_frame_packer #(.FRAME_LEN(4), .DATA_W(14), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst), .time_in(time_in), .trig_start(trig_start),
      .fifo1_q(fifo1_q), .fifo1_empty(fifo1_empty), .fifo1_rdreq(fifo1_rdreq),
      .fifo2_q(fifo2_q), .fifo2_empty(fifo2_empty), .fifo2_rdreq(fifo2_rdreq),
      .out_data(out_data), .out_write(out_write), .out_waitrequest(out_waitrequest),
      .frame_cnt(frame_cnt), .busy(busy), .trig_missed(trig_missed));

   always #5 clk = ~clk;

   assign fifo1_empty = (f1_wr == f1_rd);
   assign fifo2_empty = (f2_wr == f2_rd);

   // legacy-mode FIFO read: q updates one cycle after rdreq and holds otherwise
   always @(posedge clk) begin
      if (fifo1_rdreq && (f1_wr != f1_rd)) begin
         fifo1_q <= f1_mem[f1_rd];
         f1_rd   <= f1_rd + 1;
      end
      if (fifo2_rdreq && (f2_wr != f2_rd)) begin
         fifo2_q <= f2_mem[f2_rd];
         f2_rd   <= f2_rd + 1;
      end
   end

   // byte-wise reference CRC-16-CCITT
   function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [31:0] w);
      logic [15:0] c;
      c = c_in;
      for (int b = 3; b >= 0; b--) begin
         c = c ^ {w[8*b +: 8], 8'h00};
         for (int k = 0; k < 8; k++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push1(input logic [13:0] v);
      f1_mem[f1_wr] = v;
      f1_wr++;
   endtask

   task automatic push2(input logic [13:0] v);
      f2_mem[f2_wr] = v;
      f2_wr++;
   endtask

   task automatic exp_hdr(input logic [31:0] w);
      crc_m = 16'hFFFF;
      exp_q.push_back(w);
   endtask

   task automatic exp_word(input logic [31:0] w);
      exp_q.push_back(w);
   endtask

   task automatic exp_data(input logic [31:0] w);
`ifdef PACK_CRC_EN
      crc_m = crc_ref(crc_m, w);
`endif
      exp_q.push_back(w);
   endtask

   task automatic exp_trail(input logic [15:0] hi);
`ifdef PACK_CRC_EN
      exp_q.push_back({hi, crc_m});
`else
      exp_q.push_back({hi, 16'h0000});
`endif
   endtask

   task automatic pair(input logic [13:0] c1, input logic [13:0] c2, input logic [31:0] w);
      push1(c1);
      push2(c2);
      exp_data(w);
   endtask

   task automatic trig();
      trig_start = 1'b1;
      cyc(1);
      trig_start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && (n < 400)) begin
         cyc(1);
         n++;
      end
      chk({nm, "_done"}, busy, 1'b0);
      chk({nm, "_drained"}, exp_rd, exp_q.size());
   endtask

   task automatic monitor();
      logic        stall_prev;
      logic [31:0] prev_data;
      stall_prev = 1'b0;
      prev_data  = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("hold_write", out_write, 1'b1);
               chk("hold_data", out_data, prev_data);
            end
            if (out_write && !out_waitrequest) begin
               if (exp_rd >= exp_q.size()) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word: got %h expected none", out_data);
               end else begin
                  chk($sformatf("word%0d", exp_rd), out_data, exp_q[exp_rd]);
                  exp_rd++;
               end
            end
            stall_prev = out_write && out_waitrequest;
            prev_data  = out_data;
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      // reset state
      cyc(3);
      rst = 1'b0;
      chk("rst_write", out_write, 1'b0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_fcnt", frame_cnt, 16'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_missed", trig_missed, 1'b0);
      chk("rst_rdreq", fifo1_rdreq, 1'b0);

      // T1: full frame, no stall
      time_in = 40'h12_3456789A;
      exp_hdr(32'hA500_0000);
      exp_word(32'hB500_0012);
      exp_word(32'h3456_789A);
      pair(14'h0001, 14'h0002, 32'h0002_0001);
      pair(14'h3FFF, 14'h0000, 32'h0000_3FFF);
      pair(14'h0000, 14'h3FFF, 32'h3FFF_0000);
      pair(14'h1234, 14'h2ABC, 32'h2ABC_1234);
      exp_trail(16'hE004);
      trig();
      chk("t1_busy", busy, 1'b1);
      wait_idle("t1");
      chk("t1_fcnt", frame_cnt, 16'd1);

      // T2: sink stall during DATA
      time_in = 40'hFF_0000_0001;
      exp_hdr(32'hA500_0001);
      exp_word(32'hB500_00FF);
      exp_word(32'h0000_0001);
      pair(14'h0011, 14'h0022, 32'h0022_0011);
      pair(14'h0033, 14'h0044, 32'h0044_0033);
      pair(14'h0055, 14'h0066, 32'h0066_0055);
      pair(14'h0077, 14'h0088, 32'h0088_0077);
      exp_trail(16'hE004);
      trig();
      cyc(5);
      out_waitrequest = 1'b1;
      cyc(5);
      out_waitrequest = 1'b0;
      wait_idle("t2");
      chk("t2_fcnt", frame_cnt, 16'd2);

      // T3: ch2 empty holds off popping
      time_in = 40'd0;
      exp_hdr(32'hA500_0002);
      exp_word(32'hB500_0000);
      exp_word(32'h0000_0000);
      exp_data(32'h0200_0100);
      exp_data(32'h0201_0101);
      exp_data(32'h0202_0102);
      exp_data(32'h0203_0103);
      exp_trail(16'hE004);
      for (int i = 0; i < 4; i++) begin
         push1(14'h0100 + 14'(i));
      end
      trig();
      for (int i = 0; i < 20; i++) begin
         chk("t3_rdreq1", fifo1_rdreq, 1'b0);
         chk("t3_rdreq2", fifo2_rdreq, 1'b0);
         cyc(1);
      end
      for (int i = 0; i < 4; i++) begin
         push2(14'h0200 + 14'(i));
      end
      wait_idle("t3");
      chk("t3_fcnt", frame_cnt, 16'd3);

      // T4: short frame closed by timeout, then an empty frame
      exp_hdr(32'hA500_0003);
      exp_word(32'hB500_0000);
      exp_word(32'h0000_0000);
      pair(14'h0AAA, 14'h1555, 32'h1555_0AAA);
      pair(14'h1555, 14'h0AAA, 32'h0AAA_1555);
      exp_trail(16'hE802);
      trig();
      wait_idle("t4");
      exp_hdr(32'hA500_0004);
      exp_word(32'hB500_0000);
      exp_word(32'h0000_0000);
      exp_trail(16'hE800);
      trig();
      wait_idle("t4b");
      chk("t4_fcnt", frame_cnt, 16'd5);

      // T5: trigger while busy is reported and ignored
      exp_hdr(32'hA500_0005);
      exp_word(32'hB500_0000);
      exp_word(32'h0000_0000);
      pair(14'h0001, 14'h0001, 32'h0001_0001);
      exp_data(32'h0002_0002);
      exp_data(32'h0003_0003);
      exp_data(32'h0004_0004);
      exp_trail(16'hE004);
      trig();
      cyc(8);
      trig();
      chk("t5_missed", trig_missed, 1'b1);
      chk("t5_busy", busy, 1'b1);
      cyc(1);
      chk("t5_missed_end", trig_missed, 1'b0);
      for (int i = 2; i <= 4; i++) begin
         push1(14'(i));
         push2(14'(i));
      end
      wait_idle("t5");
      chk("t5_fcnt", frame_cnt, 16'd6);

      // T5b: reset in the middle of DATA aborts the frame
      exp_hdr(32'hA500_0006);
      exp_word(32'hB500_0000);
      exp_word(32'h0000_0000);
      pair(14'h3000, 14'h0FFF, 32'h0FFF_3000);
      trig();
      cyc(12);
      chk("t5b_consumed", exp_rd, exp_q.size());
      chk("t5b_busy", busy, 1'b1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("t5b_write", out_write, 1'b0);
      chk("t5b_data", out_data, 32'd0);
      chk("t5b_fcnt", frame_cnt, 16'd0);
      chk("t5b_busy0", busy, 1'b0);
      chk("t5b_missed", trig_missed, 1'b0);
      chk("t5b_rdreq", fifo1_rdreq, 1'b0);
      time_in = 40'hAB_CDEF_0123;
      exp_hdr(32'hA500_0000);
      exp_word(32'hB500_00AB);
      exp_word(32'hCDEF_0123);
      pair(14'h0005, 14'h000A, 32'h000A_0005);
      pair(14'h0006, 14'h000B, 32'h000B_0006);
      pair(14'h0007, 14'h000C, 32'h000C_0007);
      pair(14'h0008, 14'h000D, 32'h000D_0008);
      exp_trail(16'hE004);
      trig();
      wait_idle("t5c");
      chk("t5c_fcnt", frame_cnt, 16'd1);

      // T6: single data word 0x00010002, closed short
      time_in = 40'd0;
      exp_hdr(32'hA500_0001);
      exp_word(32'hB500_0000);
      exp_word(32'h0000_0000);
      pair(14'h0002, 14'h0001, 32'h0001_0002);
      exp_trail(16'hE801);
      trig();
      wait_idle("t6");
      chk("t6_fcnt", frame_cnt, 16'd2);

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
